// File: rtl/pipe_scoreboard_if.sv
// Decode/write-back side signals of the register scoreboard.
// master = core pipeline driving issue/check/retire, slave = the scoreboard itself.
interface pipe_scoreboard_if #(
   parameter int unsigned NREG  = 32,
   parameter int unsigned NSPEC = 6,
   parameter int unsigned NREAD = 2,
   parameter int unsigned AW    = $clog2(NREG)
);
   logic                  issue_valid;
   logic [AW-1:0]         issue_rd;
   logic [NSPEC-1:0]      issue_spec;
   logic                  issue_ready;
   logic [NREAD*AW-1:0]   chk_rs;
   logic [NREAD-1:0]      chk_allow;
   logic [NSPEC-1:0]      chk_spec;
   logic                  spec_allow;
   logic                  wb_valid;
   logic [AW-1:0]         wb_rd;
   logic [NSPEC-1:0]      wb_spec;
   logic                  flush;
   logic                  busy;
   logic                  err;

   modport master (
      output issue_valid, issue_rd, issue_spec, chk_rs, chk_spec,
             wb_valid, wb_rd, wb_spec, flush,
      input  issue_ready, chk_allow, spec_allow, busy, err
   );

   modport slave (
      input  issue_valid, issue_rd, issue_spec, chk_rs, chk_spec,
             wb_valid, wb_rd, wb_spec, flush,
      output issue_ready, chk_allow, spec_allow, busy, err
   );
endinterface

// File: rtl/pipe_scoreboard.sv
// Register scoreboard with a saturating in-flight write counter per GPR and special register.
// Decode stalls on nonzero source counters; write-back decrements; underflow sets a sticky err.
module pipe_scoreboard #(
   parameter int unsigned NREG  = 32,
   parameter int unsigned NSPEC = 6,
   parameter int unsigned CNT_W = 2,
   parameter int unsigned NREAD = 2,
   parameter int unsigned AW    = $clog2(NREG)
) (
   input logic               clk,
   input logic               reset,
   pipe_scoreboard_if.slave  sb
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   // GPR 0 is hard-wired zero, so it has no counter.
   logic [CNT_W-1:0] gpr_cnt_q  [1:NREG-1];
   logic [CNT_W-1:0] gpr_cnt_d  [1:NREG-1];
   logic [CNT_W-1:0] spec_cnt_q [NSPEC];
   logic [CNT_W-1:0] spec_cnt_d [NSPEC];
   logic             err_q, err_d;

   logic [NREG-1:0]  gpr_zero, gpr_full;
   logic [NSPEC-1:0] spec_zero, spec_full;
   logic [AW-1:0]    issue_rd_c, wb_rd_c;
   logic             issue_ready;
   logic             issue_acc, wb_acc;

   function automatic logic [AW-1:0] clamp_idx(input logic [AW-1:0] idx);
      return (32'(idx) < NREG) ? idx : '0;
   endfunction

   always_comb begin
      gpr_zero = '1;
      gpr_full = '0;
      for (int i = 1; i < NREG; i++) begin
         gpr_zero[i] = (gpr_cnt_q[i] == '0);
         gpr_full[i] = (gpr_cnt_q[i] == CntMax);
      end
      for (int s = 0; s < NSPEC; s++) begin
         spec_zero[s] = (spec_cnt_q[s] == '0);
         spec_full[s] = (spec_cnt_q[s] == CntMax);
      end
   end

   // All status outputs look at registered counters only; nothing is bypassed.
   always_comb begin
      issue_rd_c  = clamp_idx(sb.issue_rd);
      wb_rd_c     = clamp_idx(sb.wb_rd);
      issue_ready = ~(gpr_full[issue_rd_c] | (|(sb.issue_spec & spec_full)));
      issue_acc   = sb.issue_valid & issue_ready & ~sb.flush;
      wb_acc      = sb.wb_valid & ~sb.flush;
   end

   always_comb begin
      sb.issue_ready = issue_ready;
      for (int p = 0; p < NREAD; p++) begin
         sb.chk_allow[p] = gpr_zero[clamp_idx(sb.chk_rs[p*AW +: AW])];
      end
      sb.spec_allow = ~|(sb.chk_spec & ~spec_zero);
      sb.busy       = ~(&gpr_zero) | ~(&spec_zero);
      sb.err        = err_q;
   end

   always_comb begin
      logic inc, dec;
      err_d = err_q;
      for (int i = 1; i < NREG; i++) begin
         gpr_cnt_d[i] = gpr_cnt_q[i];
         inc = issue_acc && (issue_rd_c == AW'(i));
         dec = wb_acc && (wb_rd_c == AW'(i));
         if (inc && !dec) begin
            gpr_cnt_d[i] = gpr_cnt_q[i] + CNT_W'(1);
         end else if (dec && !inc) begin
            if (gpr_cnt_q[i] == '0) err_d = 1'b1;
            else                    gpr_cnt_d[i] = gpr_cnt_q[i] - CNT_W'(1);
         end
         if (sb.flush) gpr_cnt_d[i] = '0;
      end
      for (int s = 0; s < NSPEC; s++) begin
         spec_cnt_d[s] = spec_cnt_q[s];
         inc = issue_acc && sb.issue_spec[s];
         dec = wb_acc && sb.wb_spec[s];
         if (inc && !dec) begin
            spec_cnt_d[s] = spec_cnt_q[s] + CNT_W'(1);
         end else if (dec && !inc) begin
            if (spec_cnt_q[s] == '0) err_d = 1'b1;
            else                     spec_cnt_d[s] = spec_cnt_q[s] - CNT_W'(1);
         end
         if (sb.flush) spec_cnt_d[s] = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 1; i < NREG; i++) gpr_cnt_q[i] <= '0;
         for (int s = 0; s < NSPEC; s++) spec_cnt_q[s] <= '0;
         err_q <= 1'b0;
      end else begin
         for (int i = 1; i < NREG; i++) gpr_cnt_q[i] <= gpr_cnt_d[i];
         for (int s = 0; s < NSPEC; s++) spec_cnt_q[s] <= spec_cnt_d[s];
         err_q <= err_d;
      end
   end

endmodule

// File: doc/pipe_scoreboard.md
# pipe_scoreboard

Parametrised register scoreboard for the pipelined CPU core. It tracks in-flight writes to general-purpose and special registers (HI, LO, CP0 set) so the decode stage can stall on read-after-write hazards. Unlike a single lock bit per register, each register carries a saturating in-flight write counter, so several outstanding writers to one register are tracked correctly. It also provides multiple read-check ports, an exception flush, and underflow error detection. It sits between decode (issue/check side) and write-back (release side).

## Interface

Parameters:
- NREG, 32: number of general-purpose registers; index 0 is hard-wired zero and never locked.
- NSPEC, 6: number of special registers, bit order {EPC, CAUSE, STATUS, BADVADDR, HI, LO} (bit 0 = LO).
- CNT_W, 2: counter width; max in-flight writes per register = 2^CNT_W − 1.
- NREAD, 2: number of GPR read-check ports.
- AW, $clog2(NREG): GPR index width (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- issue_valid  in  1  decode issues an instruction this cycle.
- issue_rd  in  AW  GPR destination; 0 means no GPR write.
- issue_spec  in  NSPEC  special-register destination mask; multi-bit allowed (e.g. MULT sets HI|LO).
- issue_ready  out  1  no target counter is saturated; issue takes effect only when issue_valid & issue_ready.
- chk_rs  in  NREAD*AW  packed GPR source indices.
- chk_allow  out  NREAD  per-port: source counter == 0 (index 0 always 1).
- chk_spec  in  NSPEC  special registers read by the decoding instruction.
- spec_allow  out  1  all counters selected by chk_spec are 0 (1 when mask is 0).
- wb_valid  in  1  write-back retires a write this cycle.
- wb_rd  in  AW  GPR retired (0 means none).
- wb_spec  in  NSPEC  special-register mask retired.
- flush  in  1  exception flush; clears all counters.
- busy  out  1  any counter nonzero.
- err  out  1  sticky underflow flag.

## Operation

- State: NREG−1 GPR counters (index 0 not stored) and NSPEC special counters, each CNT_W bits wide, plus the err flag.
- Issue is accepted when issue_valid & issue_ready. On acceptance, each targeted counter (issue_rd ≠ 0 and each set bit of issue_spec) increments by 1.
- issue_ready = 0 if any targeted counter equals 2^CNT_W − 1. It is evaluated on registered state only; a write-back to the same register in the same cycle does not raise it.
- On wb_valid, each retired counter (wb_rd ≠ 0 and each set bit of wb_spec) decrements by 1.
- Simultaneous accepted issue and write-back to the same register: counter unchanged.
- Underflow (write-back to a counter at 0 with no same-cycle accepted issue to it): counter stays at 0 and err is set. err stays set until reset.
- chk_allow, spec_allow and busy are combinational from registered counters only. Same-cycle issue or write-back is not bypassed.
- An instruction's own destination lock never blocks its own source check in the issue cycle.
- flush: next cycle all counters = 0. Issue and write-back presented in the flush cycle are ignored. err is not cleared by flush.
- The core asserts flush only once every instruction older than the excepting one has retired. Write-backs from killed instructions never arrive after flush.
- reset has priority over flush, flush over issue/write-back. reset mid-operation discards all outstanding locks.
- Indices ≥ NREG on issue_rd, wb_rd or chk_rs are treated as 0.

## Timing

- Reset values: all counters 0, err = 0.
- Derived outputs after reset: busy = 0, issue_ready = 1, chk_allow = all 1, spec_allow = 1.
- Lock latency: issue at edge N makes chk_allow drop during cycle N+1.
- Release latency: write-back at edge M makes chk_allow rise during cycle M+1 (no same-cycle bypass).
- flush at edge F: busy = 0 during cycle F+1.
- No internal pipelining; single-cycle state update.

## Test plan

- Reset, then issue rd=5: next cycle chk_rs[0]=5 gives chk_allow[0]=0 and busy=1. wb rd=5: next cycle chk_allow[0]=1 and busy=0.
- CNT_W=2: three issues to rd=7 with no write-back. issue_ready=0 for rd=7 and =1 for rd=8. After three write-backs, chk_allow=1 only after the third.
- Same-cycle issue and wb to rd=3 with counter=1: counter stays 1 and chk_allow stays 0. Issue rd=0 or chk_rs=0: no lock, allow always 1.
- issue_spec=6'b000011 (MULT): chk_spec=6'b000001 gives spec_allow=0. wb_spec=6'b000001 alone gives spec_allow=1 for LO and 0 for HI.
- Lock rd=4, rd=9 and STATUS, then flush with a concurrent wb rd=4: next cycle all allow=1, busy=0, err=0. A later wb rd=4 sets err=1, which persists through flush and clears only on reset.
- Assert reset while counters are nonzero and issue_valid=1: next cycle busy=0, issue_ready=1, err=0.
